// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one registered fpMul among NUM_REQ requesters.
// Products are tagged with the requester index and returned in issue order through a show-ahead FIFO.
module fp_mul_arbiter #(
  parameter int EXPONENT_WIDTH = 5,
  parameter int MANTISSA_WIDTH = 10,
  parameter int NUM_REQ        = 4,
  parameter int FIFO_DEPTH     = 4,
  localparam int W   = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*W-1:0]      req_a,
  input  logic [NUM_REQ*W-1:0]      req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [W-1:0]              mul_a,
  output logic [W-1:0]              mul_b,
  input  logic                      mul_sign,
  input  logic [EXPONENT_WIDTH-1:0] mul_exponent,
  input  logic [MANTISSA_WIDTH-1:0] mul_prod,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [W-1:0]              rsp_data,
  output logic                      busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshake: a requester transfers when req_valid[i] && req_ready[i]; the
  // consumer takes the head when rsp_valid && rsp_ready. Valids never wait on readies.

  logic [W-1:0]       r_mul_a;
  logic [W-1:0]       r_mul_b;
  logic [IDW-1:0]     r_ptr;
  logic               r_s1_v;
  logic [IDW-1:0]     r_s1_id;
  logic               r_s2_v;
  logic [IDW-1:0]     r_s2_id;
  logic [W-1:0]       r_fifo_data [FIFO_DEPTH];
  logic [IDW-1:0]     r_fifo_id   [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic [CW:0]        w_used;
  logic               w_can_issue;
  logic               w_found;
  logic [IDW-1:0]     w_gnt_idx;
  int                 w_scan;
  logic               w_xfer;
  logic               w_push;
  logic               w_pop;
  logic [W-1:0]       w_push_data;

  // Credits count everything already committed to a FIFO slot, so a product
  // can never arrive at a full FIFO. A same-cycle pop is deliberately ignored.
  assign w_used      = (CW+1)'(r_count) + (CW+1)'(r_s1_v) + (CW+1)'(r_s2_v);
  assign w_can_issue = w_used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
      if (!w_found && req_valid[IDW'(w_scan)]) begin
        w_found   = 1'b1;
        w_gnt_idx = IDW'(w_scan);
      end
    end
  end

  assign req_ready = (w_found && w_can_issue) ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign w_xfer    = w_found && w_can_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_ptr   <= IDW'(NUM_REQ - 1);
      r_s1_v  <= 1'b0;
      r_s1_id <= '0;
      r_s2_v  <= 1'b0;
      r_s2_id <= '0;
    end else begin
      r_s1_v  <= w_xfer;
      r_s2_v  <= r_s1_v;
      r_s2_id <= r_s1_id;
      if (w_xfer) begin
        r_mul_a <= req_a[int'(w_gnt_idx)*W +: W];
        r_mul_b <= req_b[int'(w_gnt_idx)*W +: W];
        r_s1_id <= w_gnt_idx;
        r_ptr   <= w_gnt_idx;
      end
    end
  end

  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;

  // The multiplier result is valid one cycle after its operands, i.e. while s2 holds the tag.
  assign w_push      = r_s2_v;
  assign w_push_data = {mul_sign, mul_exponent, mul_prod};
  assign rsp_valid   = (r_count != '0);
  assign w_pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_id[i]   <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_fifo_id[r_wr_ptr]   <= r_s2_id;
        r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_data = r_fifo_data[r_rd_ptr];
  assign rsp_id   = r_fifo_id[r_rd_ptr];
  assign busy     = r_s1_v | r_s2_v | (r_count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized bench for fp_mul_arbiter with a behavioural fpMul stub and an
// issue-order scoreboard derived from credit/round-robin rules.
module tb_fp_mul_arbiter;
  localparam int EW  = 5;
  localparam int MW  = 10;
  localparam int NR  = 4;
  localparam int FD  = 4;
  localparam int W   = 1 + EW + MW;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*W-1:0]   req_a = '0;
  logic [NR*W-1:0]   req_b = '0;
  logic [NR-1:0]     req_ready;
  logic [W-1:0]      mul_a, mul_b;
  logic              mul_sign;
  logic [EW-1:0]     mul_exponent;
  logic [MW-1:0]     mul_prod;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  fp_mul_arbiter #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW), .NUM_REQ(NR), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_exponent(mul_exponent), .mul_prod(mul_prod),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- fpMul stub (normal half-precision, truncating) ----------------
  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [21:0] p;
    int          e;
    logic [9:0]  m;
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return '0;
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[20:11];
      e = e + 1;
    end else begin
      m = p[19:10];
    end
    return {a[15] ^ b[15], e[4:0], m};
  endfunction

  always @(posedge clk) {mul_sign, mul_exponent, mul_prod} <= fmul(mul_a, mul_b);

  // ---------------- scoreboard state ----------------
  logic [IDW+W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int pop_cnt  = 0;
  int model_ptr = NR - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [W-1:0] rand_op();
    if ($urandom_range(0, 7) == 0) return '0;
    return {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom_range(0, 1023))};
  endfunction

  function automatic logic [NR*W-1:0] rand_ops();
    logic [NR*W-1:0] v;
    for (int i = 0; i < NR; i++) v[i*W +: W] = rand_op();
    return v;
  endfunction

  // Reference: outstanding work = accepted minus popped before this cycle;
  // round-robin search starts after the last granted requester.
  task automatic model_step();
    int            outstanding;
    int            g;
    logic [NR-1:0] exp_gnt;
    outstanding = acc_cnt - pop_cnt;
    g = -1;
    exp_gnt = '0;
    if (outstanding < FD) begin
      for (int k = 1; k <= NR; k++) begin
        if (g < 0 && req_valid[(model_ptr + k) % NR]) g = (model_ptr + k) % NR;
      end
    end
    if (g >= 0) exp_gnt[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_gnt));
    check("busy", 32'(busy), 32'(outstanding > 0));
    if (g >= 0) begin
      exp_q.push_back({IDW'(g), fmul(req_a[g*W +: W], req_b[g*W +: W])});
      exp_cyc_q.push_back(cyc);
      acc_cnt++;
      model_ptr = g;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [NR-1:0] m, input logic [NR*W-1:0] a,
                       input logic [NR*W-1:0] b, input logic rdy);
    @(negedge clk);
    cyc++;
    req_valid = m;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    #1;
    model_step();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive('0, req_a, req_b, rdy);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    acc_cnt   = 0;
    pop_cnt   = 0;
    model_ptr = NR - 1;
    repeat (hold) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        ev = (exp_q.size() > 0) && (exp_cyc_q[0] + 3 <= cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (rsp_valid && exp_q.size() > 0) begin
          check("rsp_id", 32'(rsp_id), 32'(exp_q[0][IDW+W-1:W]));
          check("rsp_data", 32'(rsp_data), 32'(exp_q[0][W-1:0]));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            pop_cnt++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NR*W-1:0] a, b;
    int              n_acc;

    do_reset(3);

    // single request: 2.0 * 3.0 from requester 0, latency 3
    a = '0; b = '0;
    a[0 +: W] = 16'h4000;
    b[0 +: W] = 16'h4200;
    drive(4'b0001, a, b, 1'b1);
    drive('0, a, b, 1'b1);
    drive('0, a, b, 1'b1);
    drive('0, a, b, 1'b1);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd0);
    check("single_data", 32'(rsp_data), 32'h4600);
    idle(3, 1'b1);

    // fairness: all requesters valid, consumer always ready
    for (int i = 0; i < 20; i++) drive('1, rand_ops(), rand_ops(), 1'b1);
    idle(6, 1'b1);

    // backpressure: 1.5 * 1.5 from requester 2 with consumer stalled
    a = '0; b = '0;
    a[2*W +: W] = 16'h3E00;
    b[2*W +: W] = 16'h3E00;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(4'b0100, a, b, 1'b0);
      n_acc += int'(req_ready[2]);
    end
    check("bp_accepts", 32'(n_acc), 32'd4);
    check("bp_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) drive(4'b0100, a, b, 1'b1);
    idle(6, 1'b1);

    // full FIFO with alternating consumer ready
    for (int i = 0; i < 6; i++) drive('1, rand_ops(), rand_ops(), 1'b0);
    for (int i = 0; i < 24; i++) drive('1, rand_ops(), rand_ops(), 1'(i % 2));
    idle(10, 1'b1);

    // zero operand passes through as 0x0000
    a = rand_ops(); b = rand_ops();
    a[1*W +: W] = 16'h0000;
    b[1*W +: W] = 16'h4200;
    drive(4'b0010, a, b, 1'b1);
    idle(3, 1'b1);
    check("zero_valid", 32'(rsp_valid), 32'd1);
    check("zero_data", 32'(rsp_data), 32'h0000);
    idle(3, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      drive(NR'($urandom_range(0, (1 << NR) - 1)), rand_ops(), rand_ops(),
            1'($urandom_range(0, 3) != 0));

    // reset with two queued and two in flight
    idle(8, 1'b1);
    for (int i = 0; i < 4; i++) drive('1, rand_ops(), rand_ops(), 1'b0);
    do_reset(2);
    idle(4, 1'b1);
    drive('1, rand_ops(), rand_ops(), 1'b1);
    check("post_reset_grant", 32'(req_ready), 32'h1);
    for (int i = 0; i < 10; i++) drive('1, rand_ops(), rand_ops(), 1'b1);

    // drain
    idle(12, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
